// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with boot cycle, branch/JALR redirect, stall,
// optional misaligned-target trap and a saturating advance counter.
//
// Configuration macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned target traps to TRAP_VECTOR, EPC captures the
//               faulting PC, TrapReturn resumes at EPC+4.
//   undefined : target bits [1:0] are forced to zero, EPC and MisalignErr are
//               tied to zero, the TRAP state is never entered and TrapReturn
//               has no effect.
//
// Parameters
//   XLEN          PC / immediate / register width
//   RESET_VECTOR  PC loaded on reset
//   TRAP_VECTOR   PC loaded on a misaligned-target trap
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   Stall         freeze PC and all state for this cycle
//   PCSrc         00/11 sequential, 01 PC+ImmExt, 10 (RS1+ImmExt)&~1
//   ImmExt, RS1   redirect operands
//   TrapReturn    leave the trap handler (TRAP state only)
//   PC            registered fetch address
//   PCPlus4       PC+4, combinational
//   PCValid       0 during the boot cycle, 1 otherwise
//   MisalignErr   one-cycle pulse following a trapped redirect
//   EPC           PC of the faulting redirect
//   InstrCnt      saturating count of non-stalled RUN/TRAP cycles
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] RS1,
    input  logic            TrapReturn,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            PCValid,
    output logic            MisalignErr,
    output logic [XLEN-1:0] EPC,
    output logic [31:0]     InstrCnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
    localparam logic [XLEN-1:0] MASK_BIT0 = ~XLEN'(1);
    localparam logic [XLEN-1:0] MASK_LOW2 = ~XLEN'(3);
    localparam logic [31:0]     CNT_MAX   = 32'hFFFF_FFFF;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_cnt_q, instr_cnt_d;

    logic [XLEN-1:0] seq_tgt;
    logic [XLEN-1:0] branch_tgt;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] tgt;

    // Candidate targets; all adds wrap modulo 2^XLEN.
    always_comb begin
        seq_tgt    = pc_q + FOUR;
        branch_tgt = pc_q + ImmExt;
        jalr_tgt   = (RS1 + ImmExt) & MASK_BIT0;
        case (PCSrc)
            2'b01:   tgt = branch_tgt;
            2'b10:   tgt = jalr_tgt;
            default: tgt = seq_tgt;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN

    logic [XLEN-1:0] epc_q, epc_d;
    logic            misalign_err_q, misalign_err_d;
    logic            misalign;

    // JALR already has bit0 cleared, so only a branch can fault on bit0.
    always_comb begin
        misalign = tgt[1] | ((PCSrc == 2'b01) & tgt[0]);
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        epc_d          = epc_q;
        instr_cnt_d    = instr_cnt_q;
        misalign_err_d = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_TRAP: begin
                if (!Stall) begin
                    if (instr_cnt_q != CNT_MAX) begin
                        instr_cnt_d = instr_cnt_q + 32'd1;
                    end
                    if ((state_q == S_TRAP) && TrapReturn) begin
                        // Resume after the faulting instruction; PCSrc ignored.
                        pc_d    = epc_q + FOUR;
                        state_d = S_RUN;
                    end else if (misalign) begin
                        // Also taken inside TRAP: EPC is overwritten.
                        epc_d          = pc_q;
                        pc_d           = TRAP_VECTOR;
                        state_d        = S_TRAP;
                        misalign_err_d = 1'b1;
                    end else begin
                        pc_d = tgt;
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_VECTOR;
            epc_q          <= '0;
            instr_cnt_q    <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            epc_q          <= epc_d;
            instr_cnt_q    <= instr_cnt_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign EPC         = epc_q;
    assign MisalignErr = misalign_err_q;

`else

    // Trapping disabled: TrapReturn has no effect.
    logic unused_trap_return;
    assign unused_trap_return = TrapReturn;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_cnt_d = instr_cnt_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!Stall) begin
                    if (instr_cnt_q != CNT_MAX) begin
                        instr_cnt_d = instr_cnt_q + 32'd1;
                    end
                    // Misaligned targets are silently aligned down.
                    pc_d = tgt & MASK_LOW2;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_VECTOR;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign EPC         = '0;
    assign MisalignErr = 1'b0;

`endif

    assign PC       = pc_q;
    assign PCPlus4  = pc_q + FOUR;
    assign PCValid  = (state_q != S_BOOT);
    assign InstrCnt = instr_cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit. A spec-level model tracks PC/EPC/count and is
// compared against the DUT on every falling edge; literal checks pin the
// model at the points the directed scenarios care about.
module tb_pc_unit;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        Stall;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] RS1;
    logic        TrapReturn;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PCValid;
    logic        MisalignErr;
    logic [31:0] EPC;
    logic [31:0] InstrCnt;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .Stall(Stall), .PCSrc(PCSrc), .ImmExt(ImmExt),
        .RS1(RS1), .TrapReturn(TrapReturn), .PC(PC), .PCPlus4(PCPlus4),
        .PCValid(PCValid), .MisalignErr(MisalignErr), .EPC(EPC),
        .InstrCnt(InstrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_live = 1'b0;
    bit          m_boot, m_trap, m_err;
    logic [31:0] m_pc, m_epc, m_cnt;

    always @(posedge clk) begin
        logic [31:0] t;
        bit          mis;
        if (rst) begin
            m_live = 1'b1; m_boot = 1'b1; m_trap = 1'b0; m_err = 1'b0;
            m_pc = 32'h0; m_epc = 32'h0; m_cnt = 32'h0;
        end else if (m_live) begin
            m_err = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (!Stall) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (TRAP_EN && m_trap && TrapReturn) begin
                    m_pc = m_epc + 4;
                    m_trap = 1'b0;
                end else begin
                    if (PCSrc == 2'b01)      t = m_pc + ImmExt;
                    else if (PCSrc == 2'b10) t = (RS1 + ImmExt) & 32'hFFFF_FFFE;
                    else                     t = m_pc + 4;
                    mis = (t[1] == 1'b1) || (PCSrc == 2'b01 && t[0] == 1'b1);
                    if (!TRAP_EN) begin
                        m_pc = {t[31:2], 2'b00};
                    end else if (mis) begin
                        m_epc = m_pc; m_pc = 32'h100; m_trap = 1'b1; m_err = 1'b1;
                    end else begin
                        m_pc = t;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_pc",    PC,       m_pc);
            chk("m_pc4",   PCPlus4,  m_pc + 32'd4);
            chk("m_valid", {31'd0, PCValid},     {31'd0, !m_boot});
            chk("m_err",   {31'd0, MisalignErr}, {31'd0, m_err});
            chk("m_epc",   EPC,      m_epc);
            chk("m_cnt",   InstrCnt, m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rs);
        PCSrc = src; ImmExt = imm; RS1 = rs;
        tick();
        PCSrc = 2'b00; ImmExt = 32'h0; RS1 = 32'h0;
    endtask

    initial begin
        rst = 1'b1; Stall = 1'b0; PCSrc = 2'b00; ImmExt = 32'h0; RS1 = 32'h0;
        TrapReturn = 1'b0;
        tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", {31'd0, PCValid}, 32'd0);
        chk("rst_cnt", InstrCnt, 32'd0);
        chk("rst_epc", EPC, 32'd0);
        rst = 1'b0;
        tick();
        chk("boot_pc", PC, 32'h0);
        chk("boot_valid", {31'd0, PCValid}, 32'd1);
        tick();
        chk("run_pc", PC, 32'h4);
        chk("run_cnt", InstrCnt, 32'd1);

        go(2'b01, 32'h0000_000C, 32'h0);
        chk("br_fwd", PC, 32'h10);
        go(2'b01, 32'hFFFF_FFF0, 32'h0);
        chk("br_back", PC, 32'h0);
        go(2'b10, 32'h0, 32'h201);
        chk("jalr", PC, 32'h200);

        go(2'b01, 32'hFFFF_FE20, 32'h0);
        chk("to_20", PC, 32'h20);
        Stall = 1'b1; PCSrc = 2'b01; ImmExt = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", PC, 32'h20);
            chk("stall_cnt", InstrCnt, 32'd5);
        end
        Stall = 1'b0;
        tick();
        chk("unstall_pc", PC, 32'h60);
        chk("unstall_cnt", InstrCnt, 32'd6);
        PCSrc = 2'b00; ImmExt = 32'h0;

        go(2'b01, 32'hFFFF_FF9C, 32'h0);
        chk("to_top", PC, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_pc4", PCPlus4, 32'h4);

        go(2'b01, 32'h40, 32'h0);
        chk("to_40", PC, 32'h40);
        go(2'b01, 32'h6, 32'h0);
        if (TRAP_EN) begin
            chk("trap_pc", PC, 32'h100);
            chk("trap_epc", EPC, 32'h40);
            chk("trap_err", {31'd0, MisalignErr}, 32'd1);
        end else begin
            chk("align_pc", PC, 32'h44);
            chk("align_err", {31'd0, MisalignErr}, 32'd0);
            chk("align_epc", EPC, 32'h0);
        end
        TrapReturn = 1'b1;
        tick();
        TrapReturn = 1'b0;
        chk("ret_pc", PC, TRAP_EN ? 32'h44 : 32'h48);
        chk("ret_err", {31'd0, MisalignErr}, 32'd0);

        go(2'b11, 32'h80, 32'h80);
        chk("src11", PC, TRAP_EN ? 32'h48 : 32'h4C);

        go(2'b10, 32'h0, 32'h102);
        chk("jalr_mis", PC, 32'h100);
        go(2'b01, 32'h2, 32'h0);
        chk("trap2_pc", PC, 32'h100);
        chk("trap2_epc", EPC, TRAP_EN ? 32'h100 : 32'h0);

        rst = 1'b1; Stall = 1'b1; TrapReturn = 1'b1; PCSrc = 2'b01; ImmExt = 32'h6;
        tick();
        chk("rst2_pc", PC, 32'h0);
        chk("rst2_valid", {31'd0, PCValid}, 32'd0);
        chk("rst2_cnt", InstrCnt, 32'd0);
        rst = 1'b0; Stall = 1'b0; PCSrc = 2'b00; ImmExt = 32'h0;
        tick();
        chk("boot2_pc", PC, 32'h0);
        tick();
        chk("tr_ignored", PC, 32'h4);
        TrapReturn = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32: PC, immediate and register operand width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100: PC value loaded on a misaligned-target trap.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port Stall, input, 1 bit: hold PC and all state this cycle.
REQ-007 Port PCSrc, input, 2 bits: 00 = sequential, 01 = branch/JAL (PC+ImmExt), 10 = JALR ((RS1+ImmExt) with bit0 cleared), 11 = treated as 00.
REQ-008 Port ImmExt, input, XLEN bits: sign-extended immediate.
REQ-009 Port RS1, input, XLEN bits: JALR base register value.
REQ-010 Port TrapReturn, input, 1 bit: return from trap handler.
REQ-011 Port PC, output, XLEN bits: current fetch address (registered).
REQ-012 Port PCPlus4, output, XLEN bits: PC+4, combinational.
REQ-013 Port PCValid, output, 1 bit: PC is a valid fetch address.
REQ-014 Port MisalignErr, output, 1 bit: one-cycle pulse on a trapped misaligned target.
REQ-015 Port EPC, output, XLEN bits: PC of the faulting redirect.
REQ-016 Port InstrCnt, output, 32 bits: count of PC advances.

Function
REQ-017 The FSM SHALL have states BOOT, RUN and TRAP, with PCValid=0 in BOOT and 1 otherwise.
REQ-018 BOOT SHALL last exactly one cycle and then go to RUN, with PC unchanged and all inputs ignored.
REQ-019 Priority in RUN and TRAP SHALL be: rst > Stall > TrapReturn (TRAP only) > PCSrc redirect > sequential.
REQ-020 While Stall=1, PC, state, EPC and InstrCnt SHALL hold, and MisalignErr SHALL be 0.
REQ-021 The sequential update SHALL be PC <= PC+4, and branch PC <= PC+ImmExt.
REQ-022 The JALR update SHALL be PC <= (RS1+ImmExt) & ~1.
REQ-023 All adds SHALL wrap modulo 2^XLEN with no overflow flag; 0xFFFF_FFFC+4 = 0x0000_0000.
REQ-024 A target is misaligned when bit1 of the computed target (after the JALR bit0 clear) is 1, or when bit0 of a branch target is 1.
REQ-025 In TRAP with TrapReturn=1 and Stall=0, the block SHALL load PC <= EPC+4, go to RUN and ignore PCSrc.
REQ-026 TrapReturn SHALL be ignored in BOOT and RUN.
REQ-027 InstrCnt SHALL increment by 1 on every non-stalled cycle in RUN or TRAP and saturate at 32'hFFFF_FFFF.
REQ-028 PCPlus4 SHALL equal PC+4 in every cycle, including BOOT.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL load PC=RESET_VECTOR, state=BOOT, EPC=0, InstrCnt=0 and MisalignErr=0, and PCValid SHALL be 0 from the next cycle.
REQ-030 rst SHALL override Stall, TrapReturn and any pending redirect or trap, including when asserted in TRAP state.

Configuration
REQ-031 Macro PC_MISALIGN_TRAP_EN SHALL select the misaligned-target behaviour.
REQ-032 With PC_MISALIGN_TRAP_EN defined, a misaligned target on a non-stalled cycle SHALL, in one edge, set EPC <= current PC, PC <= TRAP_VECTOR, state <= TRAP and MisalignErr=1 for the following cycle only.
REQ-033 With PC_MISALIGN_TRAP_EN defined, a misaligned target while already in TRAP SHALL overwrite EPC and stay in TRAP.
REQ-034 Without the macro, target bits [1:0] SHALL be forced to 0; MisalignErr and EPC SHALL be tied 0, TRAP SHALL be unreachable and TrapReturn SHALL be ignored.

Verification
REQ-035 Reset/boot: rst=1 for one edge, then release -> cycle 1: PC=0x0, PCValid=0; cycle 2: PC=0x0, PCValid=1; cycle 3: PC=0x4, InstrCnt=1.
REQ-036 Branch/JALR: PC=0x10, PCSrc=01, ImmExt=0xFFFF_FFF0 -> PC=0x0; next, PCSrc=10, RS1=0x201, ImmExt=0x0 -> PC=0x200.
REQ-037 Stall: PC=0x20, Stall=1 for 3 cycles with PCSrc=01 and ImmExt=0x40 -> PC stays 0x20 and InstrCnt unchanged; on Stall=0 -> PC=0x60.
REQ-038 Wrap: PC=0xFFFF_FFFC, PCSrc=00 -> PC=0x0000_0000, PCPlus4=0x4.
REQ-039 Trap (macro on): PC=0x40, PCSrc=01, ImmExt=0x6 -> PC=0x100, EPC=0x40, MisalignErr=1 for one cycle; TrapReturn=1 -> PC=0x44, state RUN.
REQ-040 Macro off: same stimulus as REQ-039 -> PC=0x44, MisalignErr=0, EPC=0; rst asserted mid-TRAP (macro on) -> PC=0x0, state BOOT.
